reset_ctrl: RTL and testbench

- System reset controller that sits directly upstream of the clock divider and generates its active-high synchronous reset input.
- Merges three reset sources into one clean reset:
  - the board power-on reset (asynchronous, active-low);
  - the PLL lock indication;
  - a bouncy push-button.
- Synchronises and debounces the inputs and enforces a minimum reset hold time.
- Reports the cause of the last reset and how many run-time resets have occurred.

---
 rtl/reset_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_reset_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/reset_ctrl.sv
// reset_ctrl: system reset controller feeding the clock divider's synchronous reset.
// Merges the board power-on reset, the PLL lock indication and a debounced
// push-button into one glitch-free active-high reset on clk_in. It also records
// the cause of the last reset and counts run-time resets, saturating at 255.
module reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int HOLD_CYCLES     = 16
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       btn_in,
    input  logic       locked_in,
    output logic       rst_out,
    output logic       rst_n_out,
    output logic [1:0] cause_out,
    output logic [7:0] rst_cnt_out
);

    // Reject parameter values that would break the synchronisers or the counters.
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("reset_ctrl: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
        $error("reset_ctrl: DEBOUNCE_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_chk_hold
        $error("reset_ctrl: HOLD_CYCLES must be >= 1");
    end

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    localparam logic [1:0] CAUSE_POR    = 2'b00;
    localparam logic [1:0] CAUSE_BUTTON = 2'b01;
    localparam logic [1:0] CAUSE_LOCK   = 2'b10;

    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'b00,
        HOLD      = 2'b01,
        RUN       = 2'b10
    } state_t;

    // Synchroniser chains; the last flop of each chain is the only view of
    // the raw asynchronous input that the rest of the design ever uses.
    logic [SYNC_STAGES-1:0] btn_sync_q;
    logic [SYNC_STAGES-1:0] lock_sync_q;
    logic                   btn_s;
    logic                   lock_s;

    // Debouncer state.
    logic [DB_W-1:0] db_cnt_q;
    logic [DB_W-1:0] db_cnt_d;
    logic            btn_db_q;
    logic            btn_db_d;

    // Sequencer state.
    state_t            state_q;
    state_t            state_d;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [HOLD_W-1:0] hold_cnt_d;
    logic [1:0]        cause_q;
    logic [1:0]        cause_d;
    logic [7:0]        rst_cnt_q;
    logic [7:0]        rst_cnt_d;

    // Output registers.
    logic rst_q;
    logic rst_n_q;
    logic rst_d;

    assign btn_s  = btn_sync_q[SYNC_STAGES-1];
    assign lock_s = lock_sync_q[SYNC_STAGES-1];

    // Shift the raw button and lock inputs through their synchroniser chains.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            btn_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], btn_in};
            lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked_in};
        end
    end

    // The debounced button changes only after btn_s has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_comb begin
        db_cnt_d = db_cnt_q;
        btn_db_d = btn_db_q;
        if (btn_s == btn_db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            btn_db_d = btn_s;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // Debounce counter and debounced button registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            db_cnt_q <= '0;
            btn_db_q <= 1'b0;
        end else begin
            db_cnt_q <= db_cnt_d;
            btn_db_q <= btn_db_d;
        end
    end

    // Sequencer next state: wait for a clean lock, hold reset for HOLD_CYCLES,
    // then run until lock loss (which outranks the button) forces a new reset.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        cause_d    = cause_q;
        rst_cnt_d  = rst_cnt_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s && !btn_db_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            HOLD: begin
                if (!lock_s || btn_db_q) begin
                    // Abort back to waiting; re-entry restarts the full hold.
                    state_d = WAIT_LOCK;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s || btn_db_q) begin
                    state_d = WAIT_LOCK;
                    cause_d = !lock_s ? CAUSE_LOCK : CAUSE_BUTTON;
                    if (rst_cnt_q != CNT_MAX) begin
                        rst_cnt_d = rst_cnt_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
        rst_d = (state_d != RUN);
    end

    // Sequencer state, cause and run-time reset count registers.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= WAIT_LOCK;
            hold_cnt_q <= '0;
            cause_q    <= CAUSE_POR;
            rst_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cause_q    <= cause_d;
            rst_cnt_q  <= rst_cnt_d;
        end
    end

    // Register both reset polarities so neither output can glitch.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_q   <= 1'b1;
            rst_n_q <= 1'b0;
        end else begin
            rst_q   <= rst_d;
            rst_n_q <= ~rst_d;
        end
    end

    assign rst_out     = rst_q;
    assign rst_n_out   = rst_n_q;
    assign cause_out   = cause_q;
    assign rst_cnt_out = rst_cnt_q;

endmodule

// File: tb/tb_reset_ctrl.sv
// Directed testbench for reset_ctrl (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16).
module tb_reset_ctrl;

    logic       clk_in;
    logic       rst_in;
    logic       btn_in;
    logic       locked_in;
    logic       rst_out;
    logic       rst_n_out;
    logic [1:0] cause_out;
    logic [7:0] rst_cnt_out;

    int n_checks;
    int n_pass;

    reset_ctrl #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .HOLD_CYCLES    (16)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .btn_in     (btn_in),
        .locked_in  (locked_in),
        .rst_out    (rst_out),
        .rst_n_out  (rst_n_out),
        .cause_out  (cause_out),
        .rst_cnt_out(rst_cnt_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges and land on the following falling edge, noting
    // whether rst_out was seen high at any falling edge on the way.
    task automatic run_cycles(input int n, output logic saw_hi);
        saw_hi = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_in);
            @(negedge clk_in);
            if (rst_out === 1'b1) saw_hi = 1'b1;
        end
    endtask

    // Count rising edges until rst_out reaches lvl; returns max on timeout.
    task automatic wait_rst(input logic lvl, input int max, output int edges);
        edges = 0;
        while (rst_out !== lvl && edges < max) begin
            @(posedge clk_in);
            @(negedge clk_in);
            edges++;
        end
    endtask

    initial begin
        int   e;
        int   timeouts;
        logic hi;
        logic any_hi;

        n_checks = 0;
        n_pass   = 0;
        rst_in    = 1'b0;
        btn_in    = 1'b0;
        locked_in = 1'b1;

        // Power-on reset held with lock present.
        run_cycles(5, hi);
        chk("por_rst", rst_out, 1);
        chk("por_rst_n", rst_n_out, 0);
        chk("por_cause", cause_out, 0);
        chk("por_cnt", rst_cnt_out, 0);
        rst_in = 1'b1;
        wait_rst(1'b0, 60, e);
        chk("por_release_edges", e, 19);
        chk("por_rst_n_high", rst_n_out, 1);
        run_cycles(5, hi);
        chk("por_stays_low", hi, 0);

        // Lock loss while running.
        locked_in = 1'b0;
        wait_rst(1'b1, 40, e);
        chk("lock_assert_edges", e, 3);
        chk("lock_cause", cause_out, 2);
        chk("lock_cnt", rst_cnt_out, 1);
        run_cycles(7, hi);
        locked_in = 1'b1;
        wait_rst(1'b0, 60, e);
        chk("lock_release_edges", e, 19);

        // Bouncing button must be filtered out.
        any_hi = 1'b0;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i % 2 == 0);
            run_cycles(2, hi);
            any_hi |= hi;
        end
        run_cycles(6, hi);
        any_hi |= hi;
        chk("bounce_no_reset", any_hi, 0);
        chk("bounce_cnt", rst_cnt_out, 1);

        // Stable button press and release.
        btn_in = 1'b1;
        wait_rst(1'b1, 40, e);
        chk("btn_assert_edges", e, 7);
        chk("btn_cause", cause_out, 1);
        chk("btn_cnt", rst_cnt_out, 2);
        run_cycles(3, hi);
        btn_in = 1'b0;
        wait_rst(1'b0, 60, e);
        chk("btn_release_edges", e, 23);

        // Lock drop in the middle of HOLD restarts the hold period.
        locked_in = 1'b0;
        wait_rst(1'b1, 40, e);
        chk("hold_pre_assert_edges", e, 3);
        run_cycles(3, hi);
        locked_in = 1'b1;
        run_cycles(11, hi);
        any_hi = hi;
        chk("hold_mid_rst", rst_out, 1);
        locked_in = 1'b0;
        run_cycles(6, hi);
        chk("hold_abort_cause", cause_out, 2);
        chk("hold_abort_cnt", rst_cnt_out, 3);
        chk("hold_abort_rst", rst_out, 1);
        locked_in = 1'b1;
        wait_rst(1'b0, 60, e);
        chk("hold_full_restart_edges", e, 19);

        // Button and lock loss reach the sequencer on the same edge.
        btn_in = 1'b1;
        run_cycles(4, hi);
        chk("simul_pre_rst", hi, 0);
        locked_in = 1'b0;
        wait_rst(1'b1, 40, e);
        chk("simul_assert_edges", e, 3);
        chk("simul_cause", cause_out, 2);
        chk("simul_cnt", rst_cnt_out, 4);
        run_cycles(5, hi);
        btn_in    = 1'b0;
        locked_in = 1'b1;
        wait_rst(1'b0, 60, e);
        chk("simul_release_edges", e, 23);
        chk("simul_cnt_after", rst_cnt_out, 4);

        // Saturate the run-time reset counter.
        timeouts = 0;
        for (int i = 0; i < 300; i++) begin
            locked_in = 1'b0;
            wait_rst(1'b1, 20, e);
            if (e == 20) timeouts++;
            locked_in = 1'b1;
            wait_rst(1'b0, 40, e);
            if (e == 40) timeouts++;
        end
        chk("sat_timeouts", timeouts, 0);
        chk("sat_cnt", rst_cnt_out, 255);
        chk("sat_cause", cause_out, 2);
        chk("sat_running", rst_out, 0);

        // Asynchronous power-on reset between clock edges.
        #2;
        rst_in = 1'b0;
        #1;
        chk("async_rst", rst_out, 1);
        chk("async_rst_n", rst_n_out, 0);
        chk("async_cnt", rst_cnt_out, 0);
        chk("async_cause", cause_out, 0);
        @(negedge clk_in);
        rst_in = 1'b1;
        wait_rst(1'b0, 60, e);
        chk("async_release_edges", e, 19);
        chk("async_cnt_after", rst_cnt_out, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
